// File: rtl/fade_pwm.sv
// Triangular brightness ramp feeding a PWM modulator.
// Define FADE_PWM_SYNC_EN to latch the duty once per PWM period.
module fade_pwm #(
  parameter int PWM_INTERVAL     = 1200,
  parameter int INC_DEC_INTERVAL = 10000,
  parameter int INC_DEC_MAX      = 200
) (
  input  logic clk,
  input  logic rst_n,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] pwm_value,
  output logic pwm_out,
  output logic fade_dir
);

  localparam int VW = $clog2(PWM_INTERVAL+1);
  localparam int SW = (INC_DEC_INTERVAL > 1) ?
                      $clog2(INC_DEC_INTERVAL) : 1;
  localparam int IW = (INC_DEC_MAX > 1) ?
                      $clog2(INC_DEC_MAX) : 1;

  localparam int INC_DEC_VAL = PWM_INTERVAL / INC_DEC_MAX;

  localparam logic [VW-1:0] STEP_VAL  = VW'(INC_DEC_VAL);
  localparam logic [SW-1:0] STEP_LAST = SW'(INC_DEC_INTERVAL-1);
  localparam logic [IW-1:0] INC_LAST  = IW'(INC_DEC_MAX-1);
  localparam logic [VW-1:0] PWM_LAST  = VW'(PWM_INTERVAL-1);

  typedef enum logic {
    INC = 1'b0,
    DEC = 1'b1
  } state_t;

  state_t          state;
  logic [SW-1:0]   step_cnt;
  logic [IW-1:0]   inc_cnt;
  logic [VW-1:0]   pwm_count;
  logic [VW-1:0]   cmp_val;
  logic            step;
  logic            pwm_wrap;

  assign step     = (step_cnt == STEP_LAST);
  assign pwm_wrap = (pwm_count == PWM_LAST);
  assign fade_dir = (state == INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (step) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Direction flips on the same edge as the last step,
  // so the value lands exactly on 0 or full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INC;
      pwm_value <= '0;
      inc_cnt   <= '0;
    end else if (step) begin
      unique case (state)
        INC: pwm_value <= pwm_value + STEP_VAL;
        DEC: pwm_value <= pwm_value - STEP_VAL;
        default: pwm_value <= pwm_value;
      endcase
      if (inc_cnt == INC_LAST) begin
        inc_cnt <= '0;
        state   <= (state == INC) ? DEC : INC;
      end else begin
        inc_cnt <= inc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_count <= '0;
    end else if (pwm_wrap) begin
      pwm_count <= '0;
    end else begin
      pwm_count <= pwm_count + 1'b1;
    end
  end

`ifdef FADE_PWM_SYNC_EN
  logic [VW-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (pwm_wrap) begin
      shadow <= pwm_value;
    end
  end

  assign cmp_val = shadow;
`else
  assign cmp_val = pwm_value;
`endif

  assign pwm_out = (pwm_count < cmp_val);

endmodule

// File: tb/tb_fade_pwm.sv
// Self-checking bench for fade_pwm at reduced parameters.
// Expected values come from a closed-form ramp model.
module tb_fade_pwm;

  localparam int PI  = 12;
  localparam int IDI = 4;
  localparam int IDM = 3;
  localparam int V   = PI / IDM;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pwm_value;
  logic       pwm_out;
  logic       fade_dir;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    logic [3:0] v;
    logic       d;
    logic       o;
  } exp_t;

  exp_t sb[$];

  fade_pwm #(
    .PWM_INTERVAL(PI),
    .INC_DEC_INTERVAL(IDI),
    .INC_DEC_MAX(IDM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_value(pwm_value),
    .pwm_out(pwm_out),
    .fade_dir(fade_dir)
  );

  always #5 clk = ~clk;

  function automatic int m_val(int k);
    int p;
    p = (k / IDI) % (2 * IDM);
    return (p <= IDM) ? p * V : (2 * IDM - p) * V;
  endfunction

  function automatic logic m_dir(int k);
    return ((k / IDI) % (2 * IDM)) < IDM;
  endfunction

  function automatic logic m_out(int k);
    int c;
`ifdef FADE_PWM_SYNC_EN
    c = (k < PI) ? 0 : m_val((k / PI) * PI - 1);
`else
    c = m_val(k);
`endif
    return (k % PI) < c;
  endfunction

  function automatic exp_t mk(int k);
    exp_t e;
    e.k = k;
    e.v = 4'(m_val(k));
    e.d = m_dir(k);
    e.o = m_out(k);
    return e;
  endfunction

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    n = $urandom_range(5, 40);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_rst();
    repeat (n) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_value !== 4'd0 || fade_dir !== 1'b1 ||
        pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async v=%0d d=%b o=%b need 0 1 0",
               pwm_value, fade_dir, pwm_out);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (pwm_value !== 4'd0 || fade_dir !== 1'b1 ||
        pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold v=%0d d=%b o=%b need 0 1 0",
               pwm_value, fade_dir, pwm_out);
    end
  endtask

  task automatic test_ramp();
    exp_t e;
    release_rst();
    for (int k = 1; k <= 30; k++) begin
      sb.push_back(mk(k));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_value !== e.v || fade_dir !== e.d ||
          pwm_out !== e.o) begin
        errors++;
        $display("FAIL ramp edge %0d got v=%0d d=%b o=%b need v=%0d d=%b o=%b",
                 e.k, pwm_value, fade_dir, pwm_out, e.v, e.d, e.o);
      end
      if (k == 3 || k == 4 || k == 8 || k == 12 ||
          k == 16 || k == 20 || k == 24 || k == 28) begin
        logic [3:0] lv;
        logic       ld;
        unique case (k)
          3:  begin lv = 4'd0;  ld = 1'b1; end
          4:  begin lv = 4'd4;  ld = 1'b1; end
          8:  begin lv = 4'd8;  ld = 1'b1; end
          12: begin lv = 4'd12; ld = 1'b0; end
          16: begin lv = 4'd8;  ld = 1'b0; end
          20: begin lv = 4'd4;  ld = 1'b0; end
          24: begin lv = 4'd0;  ld = 1'b1; end
          default: begin lv = 4'd4; ld = 1'b1; end
        endcase
        checks++;
        if (pwm_value !== lv || fade_dir !== ld) begin
          errors++;
          $display("FAIL ramp_pt edge %0d got v=%0d d=%b need v=%0d d=%b",
                   k, pwm_value, fade_dir, lv, ld);
        end
      end
    end
  endtask

  task automatic test_duty();
    int hi [3];
    int first_lo [3];
    int need [3];
    rst_n = 1'b0;
    #1;
    release_rst();
    for (int p = 0; p < 3; p++) begin
      hi[p] = 0;
      first_lo[p] = -1;
    end
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      #1;
      if (pwm_out === 1'b1) hi[k / PI]++;
      else if (first_lo[k / PI] < 0) first_lo[k / PI] = k % PI;
      checks++;
      if (pwm_out !== m_out(k)) begin
        errors++;
        $display("FAIL duty_cyc edge %0d got %b need %b",
                 k, pwm_out, m_out(k));
      end
    end
    need[0] = 0;
    need[1] = 8;
`ifdef FADE_PWM_SYNC_EN
    need[2] = 4;
`else
    need[2] = 0;
`endif
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (hi[p] !== need[p]) begin
        errors++;
        $display("FAIL duty_cnt period %0d got %0d need %0d",
                 p, hi[p], need[p]);
      end
    end
`ifdef FADE_PWM_SYNC_EN
    checks++;
    if (first_lo[2] !== 4) begin
      errors++;
      $display("FAIL duty_pos got %0d need 4", first_lo[2]);
    end
`endif
  endtask

  task automatic test_sync();
    int early_hi = 0;
    logic at12;
    rst_n = 1'b0;
    #1;
    release_rst();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k >= 4 && k <= 11 && pwm_out === 1'b1) early_hi++;
      if (k == 12) at12 = pwm_out;
    end
    checks++;
    if (early_hi !== 0) begin
      errors++;
      $display("FAIL sync_hold got %0d high need 0", early_hi);
    end
    checks++;
    if (at12 !== 1'b1) begin
      errors++;
      $display("FAIL sync_wrap got %b need 1", at12);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    rst_n = 1'b0;
    #1;
    release_rst();
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_value !== 4'd0 || fade_dir !== 1'b1 ||
        pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst v=%0d d=%b o=%b need 0 1 0",
               pwm_value, fade_dir, pwm_out);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      sb.push_back(mk(k));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_value !== e.v || fade_dir !== e.d ||
          pwm_out !== e.o) begin
        errors++;
        $display("FAIL restart edge %0d got v=%0d d=%b o=%b need v=%0d d=%b o=%b",
                 e.k, pwm_value, fade_dir, pwm_out, e.v, e.d, e.o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_duty();
    test_sync();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
